// File: rtl/lcd_pkg.sv
// Shared types and constants for the 16x2 HD44780 row writer.
package lcd_pkg;

   typedef enum logic [2:0] {PWRUP, INIT, LATCH, ADDR1, DATA1, ADDR2, DATA2} lcd_state_t;
   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_EXEC} lcd_phase_t;

   localparam logic [7:0] CMD_FUNC    = 8'h38;
   localparam logic [7:0] CMD_DISP    = 8'h0C;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_ROW1    = 8'h80;
   localparam logic [7:0] CMD_ROW2    = 8'hC0;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC;
         2'd1:    return CMD_DISP;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

   // Column 0 is the MSB byte; NUL shows as a space rather than a CGRAM glyph.
   function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] col);
      logic [7:0] b;
      b = 8'h00;
      for (int c = 0; c < 16; c++)
         if (col == 4'(c)) b = row[127-8*c -: 8];
      return (b == 8'h00) ? ASCII_SPACE : b;
   endfunction

endpackage

// File: rtl/lcd1602_row_writer_if.sv
// Host-side rows and LCD pin bundle; slave = the row writer, master = host/board.
interface lcd1602_row_writer_if;
   logic [127:0] top;
   logic [127:0] bottom;
   logic         lcd_rs;
   logic         lcd_rw;
   logic         lcd_en;
   logic [7:0]   lcd_data;
   logic         init_done;
   logic         frame_done;

   modport slave  (input  top, bottom,
                   output lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done);
   modport master (output top, bottom,
                   input  lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done);
endinterface

// File: rtl/lcd_byte_strobe.sv
// One LCD bus write: SETUP (EN low) -> PULSE (EN high) -> EXEC (EN low, long after clear).
module lcd_byte_strobe
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 5,
   parameter int unsigned EXEC_CYC  = 500,
   parameter int unsigned CLEAR_CYC = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   input  logic       i_rs,
   input  logic       i_long_exec,
   output logic       o_en,
   output logic [7:0] o_data,
   output logic       o_rs,
   output logic       o_done
);

   lcd_phase_t  r_phase;
   logic [31:0] r_cnt;
   logic        r_long;
   logic [31:0] w_exec_last;

   assign w_exec_last = r_long ? (CLEAR_CYC - 32'd1) : (EXEC_CYC - 32'd1);
   // done marks the last EXEC cycle so the next write can load with no gap
   assign o_done      = (r_phase == PH_EXEC) && (r_cnt == w_exec_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= PH_IDLE;
         r_cnt   <= '0;
         r_long  <= 1'b0;
         o_en    <= 1'b0;
         o_data  <= '0;
         o_rs    <= 1'b0;
      end else if (i_start) begin
         r_phase <= PH_SETUP;
         r_cnt   <= '0;
         r_long  <= i_long_exec;
         o_en    <= 1'b0;
         o_data  <= i_byte;
         o_rs    <= i_rs;
      end else begin
         case (r_phase)
            PH_SETUP: begin
               if (r_cnt == SETUP_CYC - 32'd1) begin
                  r_phase <= PH_PULSE;
                  r_cnt   <= '0;
                  o_en    <= 1'b1;
               end else r_cnt <= r_cnt + 32'd1;
            end
            PH_PULSE: begin
               if (r_cnt == PULSE_CYC - 32'd1) begin
                  r_phase <= PH_EXEC;
                  r_cnt   <= '0;
                  o_en    <= 1'b0;
               end else r_cnt <= r_cnt + 32'd1;
            end
            PH_EXEC: begin
               if (o_done) begin
                  r_phase <= PH_IDLE;
                  r_cnt   <= '0;
               end else r_cnt <= r_cnt + 32'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/lcd1602_row_writer.sv
// Power-up/init then continuous two-row refresh of a 16x2 HD44780 LCD.
// Optional LCD_CHANGE_ONLY_EN: only start a frame when the input rows differ from the last frame.
module lcd1602_row_writer
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned PULSE_CYC   = 5,
   parameter int unsigned EXEC_CYC    = 500,
   parameter int unsigned CLEAR_CYC   = 20000,
   parameter int unsigned POWERUP_CYC = 200000
) (
   input  logic                 clk,
   input  logic                 rst,
   lcd1602_row_writer_if.slave  bus
);

   lcd_state_t   r_state, w_nxt_state;
   logic [3:0]   r_idx, w_nxt_idx;
   logic [31:0]  r_cnt;
   logic [127:0] r_snap_top, r_snap_bot;
   logic         r_init_done, r_frame_done;
   logic         w_start, w_latch, w_go, w_done, w_rs, w_long;
   logic [7:0]   w_byte;
   logic         w_en, w_rs_out;
   logic [7:0]   w_data;

`ifdef LCD_CHANGE_ONLY_EN
   logic r_first;
   assign w_go = r_first || (bus.top != r_snap_top) || (bus.bottom != r_snap_bot);
`else
   assign w_go = 1'b1;
`endif

   // r_state/r_idx name the write in flight; the next write is chosen on its done cycle
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_start     = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         PWRUP: if (r_cnt == POWERUP_CYC - 32'd1) begin
            w_nxt_state = INIT; w_nxt_idx = 4'd0; w_start = 1'b1;
         end
         INIT: if (w_done) begin
            if (r_idx == 4'd3) begin
               w_nxt_state = LATCH; w_nxt_idx = 4'd0;
            end else begin
               w_nxt_idx = r_idx + 4'd1; w_start = 1'b1;
            end
         end
         LATCH: if (w_go) begin
            w_nxt_state = ADDR1; w_start = 1'b1; w_latch = 1'b1;
         end
         ADDR1: if (w_done) begin
            w_nxt_state = DATA1; w_nxt_idx = 4'd0; w_start = 1'b1;
         end
         DATA1: if (w_done) begin
            w_start = 1'b1;
            if (r_idx == 4'd15) begin
               w_nxt_state = ADDR2; w_nxt_idx = 4'd0;
            end else w_nxt_idx = r_idx + 4'd1;
         end
         ADDR2: if (w_done) begin
            w_nxt_state = DATA2; w_nxt_idx = 4'd0; w_start = 1'b1;
         end
         DATA2: if (w_done) begin
            if (r_idx == 4'd15) begin
               w_nxt_state = LATCH; w_nxt_idx = 4'd0;
            end else begin
               w_nxt_idx = r_idx + 4'd1; w_start = 1'b1;
            end
         end
         default: w_nxt_state = PWRUP;
      endcase
   end

   always_comb begin
      w_byte = CMD_ROW1;
      w_rs   = 1'b0;
      case (w_nxt_state)
         INIT:  w_byte = init_cmd(w_nxt_idx[1:0]);
         ADDR2: w_byte = CMD_ROW2;
         DATA1: begin w_byte = row_char(r_snap_top, w_nxt_idx); w_rs = 1'b1; end
         DATA2: begin w_byte = row_char(r_snap_bot, w_nxt_idx); w_rs = 1'b1; end
         default: ;
      endcase
   end

   assign w_long = (w_byte == CMD_CLEAR) && !w_rs;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= PWRUP;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_snap_top   <= '0;
         r_snap_bot   <= '0;
         r_init_done  <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef LCD_CHANGE_ONLY_EN
         r_first      <= 1'b1;
`endif
      end else begin
         r_state      <= w_nxt_state;
         r_idx        <= w_nxt_idx;
         r_cnt        <= (r_state == PWRUP) ? r_cnt + 32'd1 : '0;
         r_frame_done <= (r_state == DATA2) && w_done && (r_idx == 4'd15);
         if ((r_state == INIT) && w_done && (r_idx == 4'd3)) r_init_done <= 1'b1;
         if (w_latch) begin
            r_snap_top <= bus.top;
            r_snap_bot <= bus.bottom;
`ifdef LCD_CHANGE_ONLY_EN
            r_first    <= 1'b0;
`endif
         end
      end
   end

   lcd_byte_strobe #(
      .SETUP_CYC (SETUP_CYC),
      .PULSE_CYC (PULSE_CYC),
      .EXEC_CYC  (EXEC_CYC),
      .CLEAR_CYC (CLEAR_CYC)
   ) u_strobe (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_start),
      .i_byte      (w_byte),
      .i_rs        (w_rs),
      .i_long_exec (w_long),
      .o_en        (w_en),
      .o_data      (w_data),
      .o_rs        (w_rs_out),
      .o_done      (w_done)
   );

   assign bus.lcd_en     = w_en;
   assign bus.lcd_data   = w_data;
   assign bus.lcd_rs     = w_rs_out;
   assign bus.lcd_rw     = 1'b0;
   assign bus.init_done  = r_init_done;
   assign bus.frame_done = r_frame_done;

endmodule
